sprite_orient_sequencer: RTL and testbench

Frame-synchronous controller that sequences the orientation of a sprite bitmap: normal, XY-swap (transpose), mirror-X or mirror-Y. It steps through a programmable four-entry pattern, holding each orientation for a set number of video frames. It sits between game logic and the bitmap offset-transform stage, driving that stage's orientation controls. It changes them only at frame boundaries, so a sprite never tears mid-frame.

---
 rtl/sprite_orient_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_sprite_orient_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_orient_sequencer.sv
// ---------------------------------------------------------------------------
// sprite_orient_sequencer
//
// Frame-synchronous sequencer for the orientation controls of a sprite
// bitmap offset-transform stage. A four-entry pattern of 2-bit orientation
// codes is stepped through, with each step held for H video frames. All
// orientation changes land only in the cycle after a startOfFrame pulse, so
// the downstream stage never sees a mid-frame change.
//
// Parameters
//   FRAMES_PER_STEP : hold length used when holdFrames == 0 (1..255)
//
// Ports
//   clk           in   system/pixel clock, rising edge
//   reset         in   synchronous active-high reset
//   startOfFrame  in   one-cycle pulse marking each frame boundary
//   trigger       in   pulse: latch configuration and arm the sequence
//   stop          in   pulse: return to idle at the next frame boundary
//   enable        in   level: 0 pauses frame counting
//   oneShot       in   1 = run once and hold last step, 0 = loop
//   pattern[7:0]  in   four orientation codes, step k = pattern[2k+1:2k]
//   lastStep[1:0] in   index of the final step
//   holdFrames    in   frames per step, 0 selects FRAMES_PER_STEP
//   orient[1:0]   out  current orientation (0 normal, 1 swapXY,
//                      2 mirrorX, 3 mirrorY)
//   swapXY        out  one-hot decode of orient == 1
//   mirrorX       out  one-hot decode of orient == 2
//   mirrorY       out  one-hot decode of orient == 3
//   step[1:0]     out  current step index
//   busy          out  high while armed, running or paused
//   done          out  one-cycle pulse when a one-shot sequence completes
// ---------------------------------------------------------------------------
module sprite_orient_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       trigger,
  input  logic       stop,
  input  logic       enable,
  input  logic       oneShot,
  input  logic [7:0] pattern,
  input  logic [1:0] lastStep,
  input  logic [7:0] holdFrames,
  output logic [1:0] orient,
  output logic       swapXY,
  output logic       mirrorX,
  output logic       mirrorY,
  output logic [1:0] step,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] DEF_HOLD = 8'(FRAMES_PER_STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Pick the 2-bit orientation code for a given step out of the pattern.
  function automatic logic [1:0] sel_orient(input logic [7:0] pat,
                                            input logic [1:0] idx);
    return pat[{idx, 1'b0} +: 2];
  endfunction

  // One-hot {swapXY, mirrorX, mirrorY}; normal orientation drives none.
  function automatic logic [2:0] decode_orient(input logic [1:0] code);
    logic [2:0] d;
    d = 3'b000;
    case (code)
      2'd1:    d = 3'b100;
      2'd2:    d = 3'b010;
      2'd3:    d = 3'b001;
      default: d = 3'b000;
    endcase
    return d;
  endfunction

  state_t     state_q, state_d;
  logic       stop_pend_q, stop_pend_d;
  logic [7:0] pat_q, pat_d;
  logic [1:0] last_q, last_d;
  logic       oneshot_q, oneshot_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] orient_q, orient_d;
  logic [1:0] step_q, step_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [2:0] dec_q, dec_d;

  logic       active;
  logic       stop_acc;
  logic       trig_acc;
  logic       sof_stop;
  logic       arm_tick;
  logic       run_tick;
  logic       seq_end;
  logic [1:0] step_inc;

  // Event qualification. A stop in the same cycle as a trigger drops the
  // trigger; an accepted trigger outranks everything else (restart), and a
  // pending stop outranks normal frame processing at the boundary.
  assign active   = (state_q != S_IDLE);
  assign stop_acc = stop && active;
  assign trig_acc = trigger && !stop;
  assign sof_stop = startOfFrame && stop_pend_q && !trig_acc;
  assign arm_tick = (state_q == S_ARMED) && startOfFrame && !trig_acc && !sof_stop;
  // RUN and PAUSE share frame handling: enable alone decides whether a
  // boundary counts, so a pause never loses or adds a frame.
  assign run_tick = ((state_q == S_RUN) || (state_q == S_PAUSE)) && startOfFrame &&
                    enable && !trig_acc && !sof_stop;
  assign seq_end  = run_tick && (cnt_q == 8'd0) && (step_q == last_q) && oneshot_q;
  assign step_inc = step_q + 2'd1;

  // State and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      stop_pend_q <= 1'b0;
      pat_q       <= 8'd0;
      last_q      <= 2'd0;
      oneshot_q   <= 1'b0;
      hold_q      <= 8'd0;
      cnt_q       <= 8'd0;
      orient_q    <= 2'd0;
      step_q      <= 2'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dec_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      pat_q       <= pat_d;
      last_q      <= last_d;
      oneshot_q   <= oneshot_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      orient_q    <= orient_d;
      step_q      <= step_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      dec_q       <= dec_d;
    end
  end

  // Next-state, pending stop and configuration latch
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    pat_d       = pat_q;
    last_d      = last_q;
    oneshot_d   = oneshot_q;
    hold_d      = hold_q;

    if (trig_acc) begin
      state_d     = S_ARMED;
      stop_pend_d = 1'b0;
      pat_d       = pattern;
      last_d      = lastStep;
      oneshot_d   = oneShot;
      hold_d      = (holdFrames == 8'd0) ? DEF_HOLD : holdFrames;
    end else if (sof_stop) begin
      state_d     = S_IDLE;
      stop_pend_d = 1'b0;
    end else begin
      if (stop_acc) begin
        stop_pend_d = 1'b1;
      end
      case (state_q)
        S_ARMED: begin
          if (arm_tick) begin
            state_d = S_RUN;
          end
        end
        S_RUN, S_PAUSE: begin
          if (seq_end) begin
            state_d = S_HOLD;
          end else begin
            state_d = enable ? S_RUN : S_PAUSE;
          end
        end
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and frame-counter datapath
  always_comb begin
    orient_d = orient_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (sof_stop) begin
      orient_d = 2'd0;
      step_d   = 2'd0;
      cnt_d    = 8'd0;
    end else if (arm_tick) begin
      step_d   = 2'd0;
      orient_d = sel_orient(pat_q, 2'd0);
      cnt_d    = hold_q - 8'd1;
    end else if (run_tick) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else if (step_q < last_q) begin
        step_d   = step_inc;
        orient_d = sel_orient(pat_q, step_inc);
        cnt_d    = hold_q - 8'd1;
      end else if (!oneshot_q) begin
        step_d   = 2'd0;
        orient_d = sel_orient(pat_q, 2'd0);
        cnt_d    = hold_q - 8'd1;
      end else begin
        // One-shot complete: orientation and step stay where they are.
        done_d = 1'b1;
      end
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_RUN) || (state_d == S_PAUSE);
    dec_d  = decode_orient(orient_d);
  end

  assign orient  = orient_q;
  assign step    = step_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign swapXY  = dec_q[2];
  assign mirrorX = dec_q[1];
  assign mirrorY = dec_q[0];

endmodule

// File: tb/tb_sprite_orient_sequencer.sv
module tb_sprite_orient_sequencer;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       trigger;
  logic       stop;
  logic       enable;
  logic       oneShot;
  logic [7:0] pattern;
  logic [1:0] lastStep;
  logic [7:0] holdFrames;
  logic [1:0] orient;
  logic       swapXY;
  logic       mirrorX;
  logic       mirrorY;
  logic [1:0] step;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_orient_sequencer #(.FRAMES_PER_STEP(5)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .trigger(trigger),
    .stop(stop), .enable(enable), .oneShot(oneShot), .pattern(pattern),
    .lastStep(lastStep), .holdFrames(holdFrames), .orient(orient),
    .swapXY(swapXY), .mirrorX(mirrorX), .mirrorY(mirrorY), .step(step),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic arm(input logic [7:0] pat, input logic [1:0] ls,
                     input logic [7:0] hf, input logic os);
    pattern    = pat;
    lastStep   = ls;
    holdFrames = hf;
    oneShot    = os;
    trigger    = 1'b1;
    tick();
    trigger    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (orient !== 2'd0) begin n_fail++; $display("FAIL reset_orient got %0d exp 0", orient); end
    n_checks++; if (step !== 2'd0) begin n_fail++; $display("FAIL reset_step got %0d exp 0", step); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", done); end
    // Reset in the middle of a running loop
    arm(8'b11_10_01_00, 2'd3, 8'd1, 1'b0);
    sof(); sof();
    n_checks++; if (orient !== 2'd1) begin n_fail++; $display("FAIL reset_prerun_orient got %0d exp 1", orient); end
    do_reset();
    n_checks++; if (orient !== 2'd0 || step !== 2'd0) begin n_fail++; $display("FAIL reset_midrun got orient %0d step %0d exp 0 0", orient, step); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_midrun_flags got busy %0b done %0b exp 0 0", busy, done); end
    sof(); idle(2); sof();
    n_checks++; if (orient !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_sof_ignored got orient %0d busy %0b exp 0 0", orient, busy); end
  endtask

  task automatic test_loop();
    logic [1:0] exp_o [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [2:0] exp_dec [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
    do_reset();
    arm(8'b11_10_01_00, 2'd3, 8'd2, 1'b0);
    n_checks++; if (busy !== 1'b1 || orient !== 2'd0) begin n_fail++; $display("FAIL loop_armed got busy %0b orient %0d exp 1 0", busy, orient); end
    for (int i = 0; i < 10; i++) begin
      sof();
      n_checks++; if (orient !== exp_o[i] || step !== exp_o[i]) begin n_fail++; $display("FAIL loop_frame%0d got orient %0d step %0d exp %0d", i, orient, step, exp_o[i]); end
      n_checks++; if ({swapXY, mirrorX, mirrorY} !== exp_dec[exp_o[i]]) begin n_fail++; $display("FAIL loop_decode%0d got %03b exp %03b", i, {swapXY, mirrorX, mirrorY}, exp_dec[exp_o[i]]); end
      idle(3);
      n_checks++; if (orient !== exp_o[i]) begin n_fail++; $display("FAIL loop_midframe%0d got %0d exp %0d", i, orient, exp_o[i]); end
    end
  endtask

  task automatic test_oneshot_default();
    logic [1:0] exp_o [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    do_reset();
    arm(8'h04, 2'd1, 8'd0, 1'b1);
    for (int f = 0; f < 11; f++) begin
      sof();
      n_checks++; if (orient !== exp_o[f]) begin n_fail++; $display("FAIL oneshot_orient sof%0d got %0d exp %0d", f + 1, orient, exp_o[f]); end
      n_checks++; if (done !== (f == 10)) begin n_fail++; $display("FAIL oneshot_done sof%0d got %0b exp %0b", f + 1, done, (f == 10)); end
      n_checks++; if (busy !== (f != 10)) begin n_fail++; $display("FAIL oneshot_busy sof%0d got %0b exp %0b", f + 1, busy, (f != 10)); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL oneshot_done_width sof%0d got %0b exp 0", f + 1, done); end
    end
    sof(); idle(2); sof();
    n_checks++; if (orient !== 2'd1 || swapXY !== 1'b1 || step !== 2'd1) begin n_fail++; $display("FAIL oneshot_hold got orient %0d swap %0b step %0d exp 1 1 1", orient, swapXY, step); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL oneshot_hold_flags got busy %0b done %0b exp 0 0", busy, done); end
  endtask

  task automatic test_pause();
    do_reset();
    arm(8'b00_00_10_01, 2'd1, 8'd3, 1'b0);
    sof(); sof();
    n_checks++; if (orient !== 2'd1) begin n_fail++; $display("FAIL pause_pre got %0d exp 1", orient); end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(2); sof();
      n_checks++; if (orient !== 2'd1 || step !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL pause_frozen%0d got orient %0d step %0d busy %0b exp 1 0 1", i, orient, step, busy); end
    end
    enable = 1'b1;
    idle(2); sof();
    n_checks++; if (orient !== 2'd1) begin n_fail++; $display("FAIL pause_resume_last got %0d exp 1", orient); end
    idle(2); sof();
    n_checks++; if (orient !== 2'd2 || step !== 2'd1) begin n_fail++; $display("FAIL pause_resume_next got orient %0d step %0d exp 2 1", orient, step); end
  endtask

  task automatic test_stop();
    do_reset();
    arm(8'b11_10_01_00, 2'd3, 8'd1, 1'b0);
    sof(); sof();
    idle(2);
    stop = 1'b1; tick(); stop = 1'b0;
    idle(3);
    n_checks++; if (orient !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL stop_pending got orient %0d busy %0b exp 1 1", orient, busy); end
    sof();
    n_checks++; if (orient !== 2'd0 || step !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle got orient %0d step %0d busy %0b exp 0 0 0", orient, step, busy); end
    // Stop coincident with a frame boundary takes effect one frame later
    arm(8'b11_10_01_00, 2'd3, 8'd1, 1'b0);
    sof();
    stop = 1'b1; sof(); stop = 1'b0;
    n_checks++; if (orient !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL stop_sof_same got orient %0d busy %0b exp 1 1", orient, busy); end
    idle(2); sof();
    n_checks++; if (orient !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_sof_next got orient %0d busy %0b exp 0 0", orient, busy); end
    // Stop and trigger together while running: stop wins
    arm(8'b11_10_01_00, 2'd3, 8'd1, 1'b0);
    sof(); sof();
    stop = 1'b1; trigger = 1'b1; pattern = 8'hFF; tick(); stop = 1'b0; trigger = 1'b0;
    idle(2); sof();
    n_checks++; if (orient !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_trig_collision got orient %0d busy %0b exp 0 0", orient, busy); end
    // Stop and trigger together while idle: nothing arms
    stop = 1'b1; trigger = 1'b1; tick(); stop = 1'b0; trigger = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_trig_idle got busy %0b exp 0", busy); end
  endtask

  task automatic test_trigger_on_sof();
    do_reset();
    pattern = 8'b00_00_00_11; lastStep = 2'd0; holdFrames = 8'd1; oneShot = 1'b0;
    trigger = 1'b1; startOfFrame = 1'b1; tick(); trigger = 1'b0; startOfFrame = 1'b0;
    n_checks++; if (busy !== 1'b1 || orient !== 2'd0) begin n_fail++; $display("FAIL trig_sof_armed got busy %0b orient %0d exp 1 0", busy, orient); end
    idle(2); sof();
    n_checks++; if (orient !== 2'd3 || mirrorY !== 1'b1) begin n_fail++; $display("FAIL trig_sof_run got orient %0d mirrorY %0b exp 3 1", orient, mirrorY); end
    idle(2); sof();
    n_checks++; if (orient !== 2'd3 || step !== 2'd0) begin n_fail++; $display("FAIL trig_sof_repeat got orient %0d step %0d exp 3 0", orient, step); end
  endtask

  task automatic test_retrigger();
    do_reset();
    arm(8'b11_10_01_00, 2'd3, 8'd2, 1'b0);
    sof(); sof(); sof();
    n_checks++; if (orient !== 2'd1) begin n_fail++; $display("FAIL retrig_pre got %0d exp 1", orient); end
    pattern = 8'b01_01_11_10; holdFrames = 8'd1; lastStep = 2'd1;
    sof();
    n_checks++; if (orient !== 2'd1) begin n_fail++; $display("FAIL retrig_noeffect1 got %0d exp 1", orient); end
    sof();
    n_checks++; if (orient !== 2'd2 || step !== 2'd2) begin n_fail++; $display("FAIL retrig_noeffect2 got orient %0d step %0d exp 2 2", orient, step); end
    trigger = 1'b1; tick(); trigger = 1'b0;
    idle(2);
    n_checks++; if (orient !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL retrig_armed got orient %0d busy %0b exp 2 1", orient, busy); end
    sof();
    n_checks++; if (orient !== 2'd2 || step !== 2'd0) begin n_fail++; $display("FAIL retrig_step0 got orient %0d step %0d exp 2 0", orient, step); end
    sof();
    n_checks++; if (orient !== 2'd3 || step !== 2'd1) begin n_fail++; $display("FAIL retrig_step1 got orient %0d step %0d exp 3 1", orient, step); end
    sof();
    n_checks++; if (orient !== 2'd2 || step !== 2'd0) begin n_fail++; $display("FAIL retrig_wrap got orient %0d step %0d exp 2 0", orient, step); end
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; trigger = 1'b0; stop = 1'b0;
    enable = 1'b1; oneShot = 1'b0; pattern = 8'd0; lastStep = 2'd0; holdFrames = 8'd0;
    test_reset();
    test_loop();
    test_oneshot_default();
    test_pause();
    test_stop();
    test_trigger_on_sof();
    test_retrigger();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
